// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// register-index width and performance-counter width.
package hazard_pkg;
   localparam int REG_IDX_W = 5;
   localparam int CNT_W     = 32;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_HALT     = 2'd2;

   typedef enum logic [1:0] {
      RUN      = ST_RUN,
      MEM_WAIT = ST_MEM_WAIT,
      HALT     = ST_HALT
   } ctrl_state_e;
endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating increment-enable counter used for hazard performance statistics.
module hazard_perf_counter
   import hazard_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for load-use, taken-branch and memory-wait hazards
// with a memory-timeout watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int WAIT_CNT_W  = 8,
   parameter int MEM_TIMEOUT = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] read_reg_idx_1_ID,
   input  logic [REG_IDX_W-1:0] read_reg_idx_2_ID,
   input  logic                 use_rs1_ID,
   input  logic                 use_rs2_ID,
   input  logic [REG_IDX_W-1:0] write_reg_idx_EX,
   input  logic                 write_reg_flag_EX,
   input  logic                 mem_to_reg_flag_EX,
   input  logic                 branch_taken_EX,
   input  logic                 mem_req_MEM,
   input  logic                 mem_ready_MEM,
   input  logic                 clear_err,
   output logic                 stall_front,
   output logic                 stall_back,
   output logic                 bubble_EX,
   output logic                 bubble_WB,
   output logic                 flush_ID,
   output logic                 mem_timeout,
   output logic [1:0]           ctrl_state,
   output logic [CNT_W-1:0]     stall_cycles_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);
   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

   ctrl_state_e           state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                  timeout_q, timeout_d;
   logic                  load_use, mem_busy, freeze, resolve;

   assign load_use = mem_to_reg_flag_EX && write_reg_flag_EX && (write_reg_idx_EX != '0) &&
                     ((use_rs1_ID && (write_reg_idx_EX == read_reg_idx_1_ID)) ||
                      (use_rs2_ID && (write_reg_idx_EX == read_reg_idx_2_ID)));
   assign mem_busy = mem_req_MEM && !mem_ready_MEM;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      freeze      = 1'b0;
      resolve     = 1'b0;
      stall_front = 1'b0;
      stall_back  = 1'b0;
      bubble_EX   = 1'b0;
      bubble_WB   = 1'b0;
      flush_ID    = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_busy) begin
               freeze     = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_CNT_W'(1);
            end else begin
               resolve = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready_MEM) begin
               resolve    = 1'b1;
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TIMEOUT_VAL) begin
               freeze    = 1'b1;
               state_d   = HALT;
               timeout_d = 1'b1;
            end else begin
               freeze     = 1'b1;
               wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
            end
         end
         HALT: begin
            // The access stays frozen so it is retried once the error is cleared.
            freeze = 1'b1;
            if (clear_err) begin
               state_d    = RUN;
               timeout_d  = 1'b0;
               wait_cnt_d = '0;
            end
         end
         default: state_d = RUN;
      endcase

      if (freeze) begin
         stall_front = 1'b1;
         stall_back  = 1'b1;
         bubble_WB   = 1'b1;
      end else if (resolve) begin
         // A taken branch kills the ID instruction, so its load-use hazard is moot.
         if (branch_taken_EX) begin
            flush_ID  = 1'b1;
            bubble_EX = 1'b1;
         end else if (load_use) begin
            stall_front = 1'b1;
            bubble_EX   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign ctrl_state  = state_q;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (stall_front),
      .cnt_o (stall_cycles_cnt)
   );

   hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (flush_ID),
      .cnt_o (flush_cnt)
   );
`else
   assign stall_cycles_cnt = '0;
   assign flush_cnt        = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
   localparam int MT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rs1, rs2, wr_idx;
   logic        use1, use2, wr_flag, m2r, br, req, rdy, clr;
   logic        stall_front, stall_back, bubble_EX, bubble_WB, flush_ID, mem_timeout;
   logic [1:0]  ctrl_state;
   logic [31:0] stall_cycles_cnt, flush_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: access-level view (halted / waiting, freeze cycles spent on the access).
   bit          m_halted, m_waiting, m_tout;
   int          m_nfreeze;
   logic [31:0] m_stall_cnt, m_flush_cnt;

   pipeline_hazard_ctrl #(.WAIT_CNT_W(8), .MEM_TIMEOUT(MT)) dut (
      .clk                (clk),
      .rst                (rst),
      .read_reg_idx_1_ID  (rs1),
      .read_reg_idx_2_ID  (rs2),
      .use_rs1_ID         (use1),
      .use_rs2_ID         (use2),
      .write_reg_idx_EX   (wr_idx),
      .write_reg_flag_EX  (wr_flag),
      .mem_to_reg_flag_EX (m2r),
      .branch_taken_EX    (br),
      .mem_req_MEM        (req),
      .mem_ready_MEM      (rdy),
      .clear_err          (clr),
      .stall_front        (stall_front),
      .stall_back         (stall_back),
      .bubble_EX          (bubble_EX),
      .bubble_WB          (bubble_WB),
      .flush_ID           (flush_ID),
      .mem_timeout        (mem_timeout),
      .ctrl_state         (ctrl_state),
      .stall_cycles_cnt   (stall_cycles_cnt),
      .flush_cnt          (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_in();
      rs1 = 0; rs2 = 0; wr_idx = 0; use1 = 0; use2 = 0; wr_flag = 0;
      m2r = 0; br = 0; req = 0; rdy = 0; clr = 0;
   endtask

   task automatic model_reset();
      m_halted = 0; m_waiting = 0; m_tout = 0; m_nfreeze = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
   endtask

   // Inputs are already driven; sample at the falling edge, then advance one clock.
   task automatic step(input string tag);
      bit lu, frz, e_sf, e_fl, e_bex;
      logic [6:0] exp_v, obs_v;
      #4;
      lu  = m2r && wr_flag && (wr_idx != 0) &&
            ((use1 && wr_idx == rs1) || (use2 && wr_idx == rs2));
      frz = m_halted || (m_waiting ? !rdy : (req && !rdy));
      e_sf = frz || (!br && lu);
      e_fl = !frz && br;
      e_bex = !frz && (br || lu);
      exp_v = {e_sf, frz, e_bex, frz, e_fl, m_tout,
               1'b0} | 7'(m_halted ? 2 : (m_waiting ? 1 : 0)) >> 0;
      exp_v = {e_sf, frz, e_bex, frz, e_fl, m_tout, 1'b0};
      obs_v = {stall_front, stall_back, bubble_EX, bubble_WB, flush_ID, mem_timeout, 1'b0};
      chk({tag, ".ctl"}, 32'(obs_v), 32'(exp_v));
      chk({tag, ".state"}, 32'(ctrl_state), m_halted ? 32'd2 : (m_waiting ? 32'd1 : 32'd0));
`ifdef HAZARD_PERF_CNT_EN
      chk({tag, ".stall_cnt"}, stall_cycles_cnt, m_stall_cnt);
      chk({tag, ".flush_cnt"}, flush_cnt, m_flush_cnt);
`else
      chk({tag, ".stall_cnt"}, stall_cycles_cnt, 32'd0);
      chk({tag, ".flush_cnt"}, flush_cnt, 32'd0);
`endif
      @(posedge clk);
      if (e_sf && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (e_fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      if (m_halted) begin
         if (clr) begin m_halted = 0; m_tout = 0; m_nfreeze = 0; end
      end else if (frz) begin
         m_nfreeze++;
         m_waiting = 1;
         if (m_nfreeze == MT + 1) begin m_halted = 1; m_waiting = 0; m_tout = 1; end
      end else begin
         m_waiting = 0; m_nfreeze = 0;
      end
      #1;
   endtask

   initial begin
      idle_in();
      model_reset();
      #23 rst = 1'b0;
      @(posedge clk); #1;

      step("reset");

      // Load-use on rs1, then the load has moved on.
      wr_idx = 5; wr_flag = 1; m2r = 1; rs1 = 5; use1 = 1;
      step("lu");
      idle_in(); rs1 = 5; use1 = 1;
      step("lu_after");
      wr_flag = 1; m2r = 1; wr_idx = 0; rs1 = 0;
      step("lu_x0");

      // Branch wins over load-use.
      idle_in(); wr_idx = 7; wr_flag = 1; m2r = 1; rs2 = 7; use2 = 1; br = 1;
      step("br_lu");
      idle_in();
      step("idle");

      // Three wait cycles then ready.
      req = 1; rdy = 0;
      for (int i = 0; i < 3; i++) step("mwait");
      rdy = 1; step("mready");
      idle_in(); step("mdone");

      // Ready in the first request cycle: no freeze.
      req = 1; rdy = 1; step("mfast");
      idle_in();

      // Timeout after MT+1 freeze cycles, then clear.
      req = 1; rdy = 0;
      for (int i = 0; i < MT + 3; i++) step("tout");
      clr = 1; step("clear");
      clr = 0; req = 0; step("post_clear");

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         wr_idx = 5'($urandom_range(0, 3));
         use1 = 1'($urandom); use2 = 1'($urandom);
         wr_flag = 1'($urandom); m2r = 1'($urandom);
         br = ($urandom_range(0, 4) == 0);
         req = ($urandom_range(0, 2) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 3) == 0);
         step("rand");
      end

      // Asynchronous reset while waiting on memory.
      idle_in(); step("pre_rst");
      req = 1; rdy = 0;
      step("rw1"); step("rw2");
      #2;
      idle_in(); rst = 1'b1;
      #1;
      chk("rst_state", 32'(ctrl_state), 32'd0);
      chk("rst_ctl", 32'({stall_front, stall_back, bubble_EX, bubble_WB, flush_ID, mem_timeout}), 32'd0);
      chk("rst_cnt", stall_cycles_cnt | flush_cnt, 32'd0);
      model_reset();
      #3 rst = 1'b0;
      @(posedge clk); #1;
      step("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
